mem_port_responder: RTL and testbench
=====================================

# mem_port_responder

Memory-side responder for the processor's data-memory ports: one write port and four read ports, each with a request/ready handshake, are serialized onto a single-port synchronous RAM. It sits between the microprocessor datapath and the RAM/cache and completes the write-port and read-port handshakes (`D_WRITE`/`D_INREADY`, `D_READn`/`D_OUTREADYn`). Arbitration: the write port has fixed priority, and reads are round-robin.

## Interface
- `ADDR_W`, default 14: address width.
- `DATA_W`, default 10: data word width.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_req`  in  1  write request; held until `wr_ready`.
- `wr_addr`  in  ADDR_W  write address; stable while `wr_req`.
- `wr_data`  in  DATA_W  write data; stable while `wr_req`.
- `wr_ready`  out  1  one-cycle pulse: write committed.
- `rd_req`  in  4  read requests, bit n = port n+1; each held until its ready.
- `rd_addr1`..`rd_addr4`  in  ADDR_W each  read addresses; stable while the request is held.
- `rd_data1`..`rd_data4`  out  DATA_W each  read data, registered; holds the last value until that port is serviced again.
- `rd_ready`  out  4  one-cycle pulse per port: `rd_dataN` valid.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_re`  out  1  RAM read enable.
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after `ram_re`.
- `busy`  out  1  high when state ≠ IDLE or any request is pending; used to drive the processor stall.

## Operation
- States:
  - IDLE: no access in flight; samples requests.
  - ACCESS: RAM strobe asserted.
  - RDONE: captures RAM read data.
- Eligibility in IDLE:
  - A port is eligible if its request is high and its ready output is low this cycle.
  - This prevents re-granting a requester in the cycle it sees ready.
- Grant in IDLE:
  - An eligible write wins over all reads.
  - Otherwise the first eligible read at or after the round-robin pointer `rr` wins (order 1→2→3→4→1).
  - On grant, latch the port index and its address, and for a write also its data.
  - Load `ram_addr`/`ram_wdata` and set `ram_we` (write) or `ram_re` (read), all registered.
  - Go to ACCESS.
- ACCESS, write:
  - Clear `ram_we`, pulse `wr_ready` next cycle, return to IDLE.
- ACCESS, read:
  - Clear `ram_re` and go to RDONE.
- RDONE:
  - Capture `ram_rdata` into the granted port's `rd_dataN`.
  - Pulse that port's `rd_ready` next cycle.
  - Set `rr` = granted port + 1 (mod 4) and return to IDLE.
- `rr` advances only on a completed read; writes do not move it.
- Write starvation of reads is permitted by design: a continuous writer blocks reads.
- Data is never modified. Width rules are identity; no address wrap logic beyond ADDR_W.
- Reset values:
  - State IDLE, `rr` = port 1.
  - `wr_ready`, `rd_ready`, `ram_we` and `ram_re` = 0.
  - `ram_addr`, `ram_wdata` and `rd_data1`..`rd_data4` = 0.
  - `busy` follows its equation.
- Reset mid-operation:
  - An in-flight access is abandoned and no ready is issued.
  - A write already strobed may have reached the RAM; the requester must re-issue after reset.

## Timing
- Request first high in cycle T (IDLE, eligible):
  - T+1: ACCESS, strobe high.
  - Write: `wr_ready` high in T+2.
  - Read: RDONE in T+2, `rd_readyN` high in T+3, with `rd_dataN` valid from T+3 onward.
- Requester handshake:
  - Deassert the request, or change the address for a new access, in the cycle after seeing ready.
  - A request held through the ready cycle is re-granted at the earliest in the following IDLE cycle.
- Ready outputs are exactly one cycle wide. At most one ready bit (write or read) is high in any cycle.
- Back-to-back throughput:
  - One write every 2 cycles.
  - One read every 3 cycles.
  - Next grant occurs in the same IDLE cycle in which the previous ready is high.
- Simultaneous requests in the same cycle are resolved only by the priority rules. There are no lost requests: unserved requests stay held.

## Test plan
- Reset, then single write `wr_addr`=0x0005, `wr_data`=10'h2A5 → `ram_we`=1 with `ram_addr`=5 in T+1; `wr_ready` pulse in T+2; `busy` low afterward.
- Read port 2 at 0x0005 after that write (model RAM) → `rd_ready[1]` pulse in T+3; `rd_data2`=10'h2A5; other `rd_data` outputs unchanged at 0.
- All four reads plus a write asserted together from reset → service order W, R1, R2, R3, R4; readies at cycles +2, +5, +8, +11, +14; `rr` ends at port 1.
- Round-robin fairness: ports 1 and 3 held permanently with the request dropped and re-raised after each ready → grants alternate 1, 3, 1, 3; neither port is granted twice in a row.
- Request held through its ready cycle → no grant in the ready cycle, re-grant the next cycle; never two readies within 2 cycles for one port.
- `rst` asserted during ACCESS of a read → next cycle state IDLE, all readies 0, `ram_re`=0, `rd_data` cleared; the held request is re-served from scratch with full T+3 latency.

Source files
------------

// File: rtl/mem_port_responder_if.sv
// Request/ready bundle between the datapath ports, the responder
// and the single-port data RAM.
interface mem_port_responder_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 10
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [3:0]        rd_req;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [ADDR_W-1:0] rd_addr3;
  logic [ADDR_W-1:0] rd_addr4;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [DATA_W-1:0] rd_data3;
  logic [DATA_W-1:0] rd_data4;
  logic [3:0]        rd_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport master (
    output wr_req, wr_addr, wr_data,
    output rd_req, rd_addr1, rd_addr2,
    output rd_addr3, rd_addr4,
    output ram_rdata,
    input  wr_ready, rd_ready,
    input  rd_data1, rd_data2,
    input  rd_data3, rd_data4,
    input  ram_addr, ram_wdata,
    input  ram_we, ram_re, busy
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr1, rd_addr2,
    input  rd_addr3, rd_addr4,
    input  ram_rdata,
    output wr_ready, rd_ready,
    output rd_data1, rd_data2,
    output rd_data3, rd_data4,
    output ram_addr, ram_wdata,
    output ram_we, ram_re, busy
  );
endinterface

// File: rtl/mem_port_responder.sv
// Serializes one write port and four round-robin read ports
// onto a single-port synchronous RAM; the write port has priority.
module mem_port_responder #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RDONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        rr_q, rr_d;
  logic              gnt_wr_q, gnt_wr_d;
  logic [1:0]        gnt_port_q, gnt_port_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic              wr_ready_q, wr_ready_d;
  logic [3:0]        rd_ready_q, rd_ready_d;
  logic [DATA_W-1:0] rd_data_q [4];
  logic [DATA_W-1:0] rd_data_d [4];

  logic [ADDR_W-1:0] rd_addr [4];
  logic              wr_elig;
  logic [3:0]        rd_elig;
  logic              rd_found;
  logic [1:0]        rd_pick;
  logic [1:0]        rd_idx;

  assign rd_addr[0] = bus.rd_addr1;
  assign rd_addr[1] = bus.rd_addr2;
  assign rd_addr[2] = bus.rd_addr3;
  assign rd_addr[3] = bus.rd_addr4;

  // A port seeing its ready this cycle is not re-granted until
  // the requester has had a chance to drop or renew the request.
  assign wr_elig = bus.wr_req & ~wr_ready_q;
  assign rd_elig = bus.rd_req & ~rd_ready_q;

  always_comb begin
    rd_found = 1'b0;
    rd_pick  = rr_q;
    rd_idx   = rr_q;
    for (int i = 0; i < 4; i++) begin
      rd_idx = rr_q + 2'(i);
      if (!rd_found && rd_elig[rd_idx]) begin
        rd_found = 1'b1;
        rd_pick  = rd_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_wr_d    = gnt_wr_q;
    gnt_port_d  = gnt_port_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    wr_ready_d  = 1'b0;
    rd_ready_d  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rd_data_d[i] = rd_data_q[i];
    end
    unique case (state_q)
      S_IDLE: begin
        priority case (1'b1)
          wr_elig: begin
            gnt_wr_d    = 1'b1;
            ram_addr_d  = bus.wr_addr;
            ram_wdata_d = bus.wr_data;
            ram_we_d    = 1'b1;
            state_d     = S_ACCESS;
          end
          rd_found: begin
            gnt_wr_d   = 1'b0;
            gnt_port_d = rd_pick;
            ram_addr_d = rd_addr[rd_pick];
            ram_re_d   = 1'b1;
            state_d    = S_ACCESS;
          end
          default: ;
        endcase
      end
      S_ACCESS: begin
        if (gnt_wr_q) begin
          wr_ready_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_RDONE;
        end
      end
      S_RDONE: begin
        rd_data_d[gnt_port_q]  = bus.ram_rdata;
        rd_ready_d[gnt_port_q] = 1'b1;
        rr_d    = gnt_port_q + 2'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 2'd0;
      gnt_wr_q    <= 1'b0;
      gnt_port_q  <= 2'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_ready_q  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        rd_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_wr_q    <= gnt_wr_d;
      gnt_port_q  <= gnt_port_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      wr_ready_q  <= wr_ready_d;
      rd_ready_q  <= rd_ready_d;
      for (int i = 0; i < 4; i++) begin
        rd_data_q[i] <= rd_data_d[i];
      end
    end
  end

  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_ready  = rd_ready_q;
  assign bus.rd_data1  = rd_data_q[0];
  assign bus.rd_data2  = rd_data_q[1];
  assign bus.rd_data3  = rd_data_q[2];
  assign bus.rd_data4  = rd_data_q[3];
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_re    = ram_re_q;
  assign bus.busy      = (state_q != S_IDLE)
                       | bus.wr_req
                       | (|bus.rd_req);

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: directed scenarios plus random
// traffic checked against a transaction-level model and model RAM.
module tb_mem_port_responder;
  localparam int AW = 14;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Single-port synchronous RAM
  logic [DW-1:0] ram [1<<AW];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= ram[bus.ram_addr];
  end

  typedef struct { int port; int cyc; } ev_t;
  ev_t log_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction-level reference model
  logic [DW-1:0] mmem [1<<AW];
  logic [DW-1:0] mdata [4];
  int free_at, rdy_cyc, rdy_port, mrr;
  logic [DW-1:0] rdy_val;
  int stb_cyc;
  bit stb_we;
  logic [AW-1:0] stb_addr;
  logic [DW-1:0] stb_wdata;

  bit auto_drop = 1'b1;
  bit prev_wr, cur_wr;
  logic [3:0] prev_rd, cur_rd;
  int t0, t1;
  int exp_p [5] = '{0, 1, 2, 3, 4};
  int exp_o [5] = '{2, 5, 8, 11, 14};

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] rd_addr_of(int p);
    case (p)
      0: return bus.rd_addr1;
      1: return bus.rd_addr2;
      2: return bus.rd_addr3;
      default: return bus.rd_addr4;
    endcase
  endfunction

  function automatic logic [DW-1:0] rd_data_of(int p);
    case (p)
      0: return bus.rd_data1;
      1: return bus.rd_data2;
      2: return bus.rd_data3;
      default: return bus.rd_data4;
    endcase
  endfunction

  task automatic set_rd_addr(int p, logic [AW-1:0] a);
    case (p)
      0: bus.rd_addr1 = a;
      1: bus.rd_addr2 = a;
      2: bus.rd_addr3 = a;
      default: bus.rd_addr4 = a;
    endcase
  endtask

  task automatic model_reset();
    free_at  = cyc + 1;
    rdy_cyc  = -1;
    rdy_port = -1;
    stb_cyc  = -1;
    mrr      = 0;
    for (int i = 0; i < 4; i++) mdata[i] = '0;
  endtask

  // Advance one clock and check the registered outputs
  task automatic tick();
    logic [3:0] ev;
    @(posedge clk);
    #1;
    cyc++;
    ev = 4'b0000;
    for (int p = 0; p < 4; p++)
      ev[p] = (rdy_cyc == cyc) && (rdy_port == p + 1);
    chk("wr_ready", bus.wr_ready,
        (rdy_cyc == cyc) && (rdy_port == 0));
    chk("rd_ready", bus.rd_ready, ev);
    if (rdy_cyc == cyc && rdy_port > 0)
      mdata[rdy_port-1] = rdy_val;
    for (int p = 0; p < 4; p++)
      chk("rd_data", rd_data_of(p), mdata[p]);
    chk("ram_we", bus.ram_we, (stb_cyc == cyc) && stb_we);
    chk("ram_re", bus.ram_re, (stb_cyc == cyc) && !stb_we);
    if (stb_cyc == cyc) begin
      chk("ram_addr", bus.ram_addr, stb_addr);
      if (stb_we) chk("ram_wdata", bus.ram_wdata, stb_wdata);
    end
    prev_wr = cur_wr;
    prev_rd = cur_rd;
    cur_wr  = bus.wr_ready;
    cur_rd  = bus.rd_ready;
    if (bus.wr_ready) log_q.push_back('{0, cyc});
    for (int p = 0; p < 4; p++)
      if (bus.rd_ready[p]) log_q.push_back('{p + 1, cyc});
  endtask

  // Inputs for this cycle are driven; check busy, model the grant
  task automatic settle();
    int pick;
    logic [AW-1:0] a;
    #1;
    chk("busy", bus.busy,
        (cyc < free_at) || bus.wr_req || (|bus.rd_req));
    if (rst) begin
      model_reset();
      return;
    end
    if (cyc < free_at) return;
    if (bus.wr_req && !(rdy_cyc == cyc && rdy_port == 0)) begin
      mmem[bus.wr_addr] = bus.wr_data;
      stb_cyc   = cyc + 1;
      stb_we    = 1'b1;
      stb_addr  = bus.wr_addr;
      stb_wdata = bus.wr_data;
      rdy_cyc   = cyc + 2;
      rdy_port  = 0;
      free_at   = cyc + 2;
      return;
    end
    pick = -1;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (mrr + k) % 4;
      if (pick < 0 && bus.rd_req[p] &&
          !(rdy_cyc == cyc && rdy_port == p + 1))
        pick = p;
    end
    if (pick >= 0) begin
      a        = rd_addr_of(pick);
      rdy_val  = mmem[a];
      stb_cyc  = cyc + 1;
      stb_we   = 1'b0;
      stb_addr = a;
      rdy_cyc  = cyc + 3;
      rdy_port = pick + 1;
      free_at  = cyc + 3;
      mrr      = (pick + 1) % 4;
    end
  endtask

  task automatic cycle();
    tick();
    if (auto_drop) begin
      if (prev_wr) bus.wr_req = 1'b0;
      for (int p = 0; p < 4; p++)
        if (prev_rd[p]) bus.rd_req[p] = 1'b0;
    end
    settle();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]  = '0;
      mmem[i] = '0;
    end
    bus.ram_rdata = '0;
    rst = 1'b1;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req = 4'b0000;
    for (int p = 0; p < 4; p++) set_rd_addr(p, '0);
    prev_wr = 1'b0; cur_wr = 1'b0;
    prev_rd = '0;   cur_rd = '0;
    model_reset();

    tick(); settle();
    tick(); rst = 1'b0; settle();
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_busy", bus.busy, 0);

    // Single write
    tick();
    bus.wr_req = 1'b1;
    bus.wr_addr = 14'h0005;
    bus.wr_data = 10'h2A5;
    settle();
    cycle();
    chk("t1_we", bus.ram_we, 1);
    chk("t1_addr", bus.ram_addr, 5);
    cycle();
    chk("t1_wrdy", bus.wr_ready, 1);
    cycle();
    chk("t1_busy", bus.busy, 0);

    // Read port 2 of the written word
    tick();
    bus.rd_req[1] = 1'b1;
    set_rd_addr(1, 14'h0005);
    settle();
    run(2);
    chk("t2_early", bus.rd_ready, 4'b0000);
    cycle();
    chk("t2_rdy", bus.rd_ready, 4'b0010);
    chk("t2_d2", bus.rd_data2, 10'h2A5);
    chk("t2_d1", bus.rd_data1, 0);
    chk("t2_d3", bus.rd_data3, 0);
    chk("t2_d4", bus.rd_data4, 0);
    run(2);

    // Everything at once straight out of reset
    tick(); rst = 1'b1; settle();
    tick(); rst = 1'b0;
    log_q.delete();
    bus.wr_req = 1'b1;
    bus.wr_addr = 14'h0007;
    bus.wr_data = 10'h155;
    bus.rd_req = 4'b1111;
    set_rd_addr(0, 14'h0007);
    set_rd_addr(1, 14'h0005);
    set_rd_addr(2, 14'h0005);
    set_rd_addr(3, 14'h0009);
    settle();
    t0 = cyc;
    run(15);
    chk("t3_cnt", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      chk("t3_port", log_q[i].port, exp_p[i]);
      chk("t3_cyc", log_q[i].cyc - t0, exp_o[i]);
    end
    chk("t3_d1", bus.rd_data1, 10'h155);
    chk("t3_d3", bus.rd_data3, 10'h2A5);
    log_q.delete();
    tick();
    bus.rd_req = 4'b1001;
    settle();
    run(10);
    chk("t3_rrcnt", log_q.size(), 2);
    if (log_q.size() > 0) chk("t3_rr", log_q[0].port, 1);

    // Round-robin between ports 1 and 3
    log_q.delete();
    for (int i = 0; i < 30; i++) begin
      tick();
      for (int p = 0; p < 4; p += 2) begin
        if (prev_rd[p]) bus.rd_req[p] = 1'b0;
        else if (!bus.rd_req[p]) begin
          bus.rd_req[p] = 1'b1;
          set_rd_addr(p, AW'($urandom_range(0, 15)));
        end
      end
      settle();
    end
    run(10);
    chk("t4_cnt", log_q.size() >= 6, 1);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      chk("t4_alt", log_q[i].port, (i % 2 == 0) ? 1 : 3);

    // Request held through its ready cycle
    log_q.delete();
    auto_drop = 1'b0;
    tick();
    bus.rd_req[3] = 1'b1;
    set_rd_addr(3, 14'h0009);
    settle();
    t0 = cyc;
    run(8);
    auto_drop = 1'b1;
    run(6);
    chk("t5_cnt", log_q.size(), 3);
    if (log_q.size() >= 2) begin
      chk("t5_first", log_q[0].cyc - t0, 3);
      chk("t5_gap", log_q[1].cyc - log_q[0].cyc, 4);
    end

    // Reset while a read is in ACCESS
    tick();
    bus.rd_req[2] = 1'b1;
    set_rd_addr(2, 14'h0005);
    settle();
    tick();
    chk("t6_re", bus.ram_re, 1);
    rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;
    chk("t6_rdy", bus.rd_ready, 4'b0000);
    chk("t6_wrdy", bus.wr_ready, 0);
    chk("t6_re0", bus.ram_re, 0);
    chk("t6_d1", bus.rd_data1, 0);
    chk("t6_d3", bus.rd_data3, 0);
    settle();
    t1 = cyc;
    log_q.delete();
    run(3);
    chk("t6_late", bus.rd_ready, 4'b0100);
    chk("t6_d3b", bus.rd_data3, 10'h2A5);
    if (log_q.size() > 0) chk("t6_cyc", log_q[0].cyc - t1, 3);
    run(3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (prev_wr) begin
        bus.wr_req = $urandom_range(0, 1) == 1;
        bus.wr_addr = AW'($urandom_range(0, 15));
        bus.wr_data = DW'($urandom);
      end else if (!bus.wr_req && $urandom_range(0, 7) == 0) begin
        bus.wr_req = 1'b1;
        bus.wr_addr = AW'($urandom_range(0, 15));
        bus.wr_data = DW'($urandom);
      end
      for (int p = 0; p < 4; p++) begin
        if (prev_rd[p]) begin
          bus.rd_req[p] = $urandom_range(0, 1) == 1;
          set_rd_addr(p, AW'($urandom_range(0, 15)));
        end else if (!bus.rd_req[p] &&
                     $urandom_range(0, 2) == 0) begin
          bus.rd_req[p] = 1'b1;
          set_rd_addr(p, AW'($urandom_range(0, 15)));
        end
      end
      settle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
